// File: rtl/add_sub.sv
// add_sub: two's-complement adder/subtractor with carry-in chaining and a
// one-cycle registered result stage. Chaining a low word's cout into the next
// word's cin (with carry=1) builds wider add/subtract operations.
// Optional feature: define ADDSUB_FLAGS_EN to add the registered ovf/zero flags.
module add_sub #(
  parameter int unsigned WORD_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] x,
  input  logic [WORD_SIZE-1:0] y,
  input  logic                 sub,
  input  logic                 cin,
  input  logic                 carry,
  output logic [WORD_SIZE-1:0] sum,
  output logic                 cout
`ifdef ADDSUB_FLAGS_EN
  ,
  output logic                 ovf,
  output logic                 zero
`endif
);

  localparam int unsigned Msb = WORD_SIZE - 1;

  logic [WORD_SIZE-1:0] yb;
  logic                 c0;
  logic [WORD_SIZE:0]   full;

  logic [WORD_SIZE-1:0] sum_d, sum_q;
  logic                 cout_d, cout_q;

  // Combinational add: subtract is x + ~y + 1 unless an external carry is chained.
  always_comb begin
    yb     = sub ? ~y : y;
    c0     = carry ? cin : sub;
    full   = {1'b0, x} + {1'b0, yb} + {{WORD_SIZE{1'b0}}, c0};
    sum_d  = full[WORD_SIZE-1:0];
    cout_d = full[WORD_SIZE];
  end

  // Result register; reset clears the outputs and discards that edge's inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

`ifdef ADDSUB_FLAGS_EN
  logic ovf_d, ovf_q;
  logic zero_d, zero_q;

  // Signed overflow: operands agree in sign but the result sign differs.
  always_comb begin
    ovf_d  = (x[Msb] == yb[Msb]) && (sum_d[Msb] != x[Msb]);
    zero_d = (sum_d == '0);
  end

  // Flag register; zero reads 0 during reset even though sum is 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign ovf  = ovf_q;
  assign zero = zero_q;
`endif

endmodule

// File: tb/tb_add_sub.sv
// Self-checking bench for add_sub (WORD_SIZE=8). Expected results are pushed
// to a scoreboard queue as stimulus is driven and popped after the edge.
module tb_add_sub;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] x, y;
  logic         sub, cin, carry;
  logic [W-1:0] sum;
  logic         cout;
`ifdef ADDSUB_FLAGS_EN
  logic         ovf, zero;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  exp_t sb[$];
  exp_t e;

  add_sub #(.WORD_SIZE(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .x     (x),
    .y     (y),
    .sub   (sub),
    .cin   (cin),
    .carry (carry),
    .sum   (sum),
    .cout  (cout)
`ifdef ADDSUB_FLAGS_EN
    ,
    .ovf   (ovf),
    .zero  (zero)
`endif
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input logic ca, input logic ci,
                                 input logic r);
    exp_t m;
    int   bb, c, t;
    m = '0;
    if (r) return m;
    bb     = s ? (255 - int'(b)) : int'(b);
    c      = ca ? int'(ci) : int'(s);
    t      = int'(a) + bb + c;
    m.sum  = t[7:0];
    m.cout = (t > 255);
    m.ovf  = (a[7] == bb[7]) && (m.sum[7] != a[7]);
    m.zero = (m.sum == 8'd0);
    return m;
  endfunction

  // Drive one operation at the falling edge, record its expectation, then
  // advance to just after the rising edge that registers it.
  task automatic step(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                      input logic ca, input logic ci, input logic r);
    @(negedge clk);
    x = a; y = b; sub = s; carry = ca; cin = ci; rst = r;
    sb.push_back(model(a, b, s, ca, ci, r));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(8'd42, 8'd69, 1'b0, 1'b0, 1'b0, 1'b1);
      e = sb.pop_front();
      n_checks++;
      if ({sum, cout} !== 9'd0 || {sum, cout} !== {e.sum, e.cout})
        $display("FAIL reset_%0d sum/cout got %0d/%0d want 0/0", i, sum, cout);
      else n_pass++;
`ifdef ADDSUB_FLAGS_EN
      n_checks++;
      if ({ovf, zero} !== 2'b00)
        $display("FAIL reset_flags_%0d got ovf=%b zero=%b want 0 0", i, ovf, zero);
      else n_pass++;
`endif
    end
    step(8'd42, 8'd69, 1'b0, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front();
    n_checks++;
    if (sum !== 8'd111 || sum !== e.sum)
      $display("FAIL reset_release sum got %0d want 111", sum);
    else n_pass++;
  endtask

  task automatic test_add();
    step(8'd42, 8'd69, 1'b0, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front();
    n_checks++;
    if (sum !== 8'd111 || cout !== 1'b0)
      $display("FAIL add sum/cout got %0d/%b want 111/0", sum, cout);
    else n_pass++;
`ifdef ADDSUB_FLAGS_EN
    n_checks++;
    if (ovf !== e.ovf || zero !== e.zero)
      $display("FAIL add_flags got %b%b want %b%b", ovf, zero, e.ovf, e.zero);
    else n_pass++;
`endif
  endtask

  task automatic test_sub();
    step(8'd52, 8'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front();
    n_checks++;
    if (sum !== 8'd42 || cout !== 1'b1)
      $display("FAIL sub52_10 sum/cout got %0d/%b want 42/1", sum, cout);
    else n_pass++;
    step(8'd255, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front();
    n_checks++;
    if (sum !== 8'd254 || cout !== 1'b1)
      $display("FAIL sub255_1 sum/cout got %0d/%b want 254/1", sum, cout);
    else n_pass++;
    step(8'd0, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front();
    n_checks++;
    if (sum !== 8'd255 || cout !== 1'b0)
      $display("FAIL sub0_1 sum/cout got %0d/%b want 255/0", sum, cout);
    else n_pass++;
  endtask

  task automatic test_add_wrap();
    step(8'd255, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front();
    n_checks++;
    if (sum !== 8'd0 || cout !== 1'b1)
      $display("FAIL wrap255_1 sum/cout got %0d/%b want 0/1", sum, cout);
    else n_pass++;
`ifdef ADDSUB_FLAGS_EN
    n_checks++;
    if (zero !== 1'b1 || ovf !== 1'b0)
      $display("FAIL wrap255_1_flags got ovf=%b zero=%b want 0 1", ovf, zero);
    else n_pass++;
`endif
    step(8'd127, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front();
    n_checks++;
    if (sum !== 8'd128 || cout !== 1'b0)
      $display("FAIL wrap127_1 sum/cout got %0d/%b want 128/0", sum, cout);
    else n_pass++;
`ifdef ADDSUB_FLAGS_EN
    n_checks++;
    if (ovf !== 1'b1 || zero !== 1'b0)
      $display("FAIL wrap127_1_flags got ovf=%b zero=%b want 1 0", ovf, zero);
    else n_pass++;
`endif
  endtask

  task automatic test_chain();
    logic [W-1:0] lo;
    logic         c;
    step(8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front();
    lo = sum;
    c  = cout;
    n_checks++;
    if (sum !== 8'hFF || cout !== 1'b0)
      $display("FAIL chain_lo sum/cout got %h/%b want ff/0", sum, cout);
    else n_pass++;
    step(8'h01, 8'h00, 1'b1, 1'b1, c, 1'b0);
    e = sb.pop_front();
    n_checks++;
    if ({sum, lo} !== 16'h00FF || cout !== 1'b1)
      $display("FAIL chain_16 result/cout got %h/%b want 00ff/1", {sum, lo}, cout);
    else n_pass++;
    // Random 16-bit chained add/sub against a wide reference.
    for (int i = 0; i < 16; i++) begin
      logic [15:0] a, b, r;
      logic        s;
      int          full;
      a = 16'($urandom); b = 16'($urandom); s = 1'($urandom);
      full = s ? (int'(a) - int'(b)) : (int'(a) + int'(b));
      r = full[15:0];
      step(a[7:0], b[7:0], s, 1'b0, 1'b0, 1'b0);
      e = sb.pop_front();
      lo = sum;
      c  = cout;
      step(a[15:8], b[15:8], s, 1'b1, c, 1'b0);
      e = sb.pop_front();
      n_checks++;
      if ({sum, lo} !== r || cout !== (s ? (a >= b) : (full > 16'hFFFF)))
        $display("FAIL chain_rand_%0d got %h/%b want %h a=%h b=%h sub=%b",
                 i, {sum, lo}, cout, r, a, b, s);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] want [4];
    want[0] = 8'd30; want[1] = 8'd10; want[2] = 8'd31; want[3] = 8'd246;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin x = 8'd10; y = 8'd20; sub = 1'b0; carry = 1'b0; cin = 1'b0; end
        1: begin x = 8'd20; y = 8'd10; sub = 1'b1; carry = 1'b0; cin = 1'b0; end
        2: begin x = 8'd10; y = 8'd20; sub = 1'b0; carry = 1'b1; cin = 1'b1; end
        default: begin x = 8'd10; y = 8'd20; sub = 1'b1; carry = 1'b0; cin = 1'b0; end
      endcase
      rst = 1'b0;
      sb.push_back(model(x, y, sub, carry, cin, 1'b0));
      @(posedge clk);
      #1;
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL b2b_%0d scoreboard empty", i);
      end else begin
        e = sb.pop_front();
        if (sum !== e.sum || cout !== e.cout || sum !== want[i])
          $display("FAIL b2b_%0d sum/cout got %0d/%b want %0d/%b", i, sum, cout, e.sum, e.cout);
        else n_pass++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      step(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      e = sb.pop_front();
      n_checks++;
      if (sum !== e.sum || cout !== e.cout)
        $display("FAIL rand_%0d sum/cout got %0d/%b want %0d/%b", i, sum, cout, e.sum, e.cout);
      else n_pass++;
`ifdef ADDSUB_FLAGS_EN
      n_checks++;
      if (ovf !== e.ovf || zero !== e.zero)
        $display("FAIL rand_flags_%0d got %b%b want %b%b", i, ovf, zero, e.ovf, e.zero);
      else n_pass++;
`endif
    end
    // Mid-stream reset: that edge's inputs are discarded, next edge resumes.
    step(8'd1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    e = sb.pop_front();
    n_checks++;
    if ({sum, cout} !== 9'd0)
      $display("FAIL midreset got %0d/%b want 0/0", sum, cout);
    else n_pass++;
    step(8'd1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front();
    n_checks++;
    if (sum !== 8'd3)
      $display("FAIL midreset_release sum got %0d want 3", sum);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1; x = '0; y = '0; sub = 1'b0; cin = 1'b0; carry = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_add_wrap();
    test_chain();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
